// File: rtl/mrd_rdx_sideband_align.sv
// Sideband aligner for the mixed-radix stage: per-lane bank index/address FIFO replayed
// on datapath output, registered results, and frame exponent. Optional MRD_SB_ERR_EN enables FIFO error flags.
module mrd_rdx_sideband_align #(
  parameter int NLANE   = 5,
  parameter int wIDX    = 3,
  parameter int wADDR   = 8,
  parameter int wD      = 18,
  parameter int DEPTH   = 32,
  parameter int wEXP    = 4,
  parameter int EXP_ACC = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sop,
  input  logic                         in_val,
  input  logic [NLANE*wIDX-1:0]        in_bank_index,
  input  logic [NLANE*wADDR-1:0]       in_bank_addr,
  input  logic                         dp_out_val,
  input  logic [NLANE*wD-1:0]          dp_real,
  input  logic [NLANE*wD-1:0]          dp_imag,
  input  logic [wEXP-1:0]              dp_exp,
  output logic                         out_val,
  output logic [NLANE*wIDX-1:0]        out_bank_index,
  output logic [NLANE*wADDR-1:0]       out_bank_addr,
  output logic [NLANE*wD-1:0]          out_real,
  output logic [NLANE*wD-1:0]          out_imag,
  output logic [wEXP-1:0]              exp_fb,
  output logic [wEXP-1:0]              exp_out,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         exp_sat,
  output logic                         err_overflow,
  output logic                         err_underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = NLANE * wIDX;
  localparam int AW = NLANE * wADDR;
  localparam int EW = IW + AW;
  localparam int DW = NLANE * wD;

  // in_val pushes and dp_out_val pops are single-cycle strobes with no ready:
  // upstream guarantees occupancy stays within DEPTH, excess beats are dropped.
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          empty, full, do_push, do_pop;
  logic [EW-1:0] rd_entry;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign do_pop   = dp_out_val & ~empty;
  assign do_push  = in_val & (~full | do_pop);
  assign level_d  = level_q + LW'(do_push) - LW'(do_pop);
  assign rd_entry = do_pop ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {in_bank_index, in_bank_addr};
  end

  logic                out_val_q, dp_val_d_q;
  logic [IW-1:0]       out_idx_q;
  logic [AW-1:0]       out_addr_q;
  logic [DW-1:0]       out_real_q, out_imag_q;
  logic [wEXP-1:0]     exp_fb_q, exp_fb_d, exp_out_q;
  logic                exp_sat_q, exp_sat_d;
  logic [wEXP:0]       exp_sum;
  logic                exp_edge;

  assign exp_edge = dp_out_val & ~dp_val_d_q;
  assign exp_sum  = {1'b0, exp_fb_q} + {1'b0, dp_exp};

  always_comb begin
    exp_fb_d  = exp_fb_q;
    exp_sat_d = exp_sat_q;
    if (sop) begin
      exp_fb_d  = '0;
      exp_sat_d = 1'b0;
    end else if (exp_edge) begin
      if (EXP_ACC != 0) begin
        if (exp_sum[wEXP]) begin
          exp_fb_d  = '1;
          exp_sat_d = 1'b1;
        end else begin
          exp_fb_d = exp_sum[wEXP-1:0];
        end
      end else begin
        exp_fb_d = dp_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_val_q  <= 1'b0;
      out_idx_q  <= '0;
      out_addr_q <= '0;
      out_real_q <= '0;
      out_imag_q <= '0;
      dp_val_d_q <= 1'b0;
      exp_fb_q   <= '0;
      exp_out_q  <= '0;
      exp_sat_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PW'(do_push);
      rd_ptr_q   <= rd_ptr_q + PW'(do_pop);
      level_q    <= level_d;
      out_val_q  <= dp_out_val;
      out_idx_q  <= rd_entry[EW-1:AW];
      out_addr_q <= rd_entry[AW-1:0];
      out_real_q <= dp_real;
      out_imag_q <= dp_imag;
      dp_val_d_q <= dp_out_val;
      exp_fb_q   <= exp_fb_d;
      exp_out_q  <= exp_fb_q;
      exp_sat_q  <= exp_sat_d;
    end
  end

`ifdef MRD_SB_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (sop) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (in_val & full & ~dp_out_val) ovf_q <= 1'b1;
      if (dp_out_val & empty)          unf_q <= 1'b1;
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  assign out_val        = out_val_q;
  assign out_bank_index = out_idx_q;
  assign out_bank_addr  = out_addr_q;
  assign out_real       = out_real_q;
  assign out_imag       = out_imag_q;
  assign exp_fb         = exp_fb_q;
  assign exp_out        = exp_out_q;
  assign fifo_level     = level_q;
  assign exp_sat        = exp_sat_q;
endmodule

// File: doc/mrd_rdx_sideband_align.md
# mrd_rdx_sideband_align

Parametrised sideband aligner for the mixed-radix (2/3/4/5) butterfly-plus-twiddle stage. It captures per-lane bank index/address on every input beat and replays them in order when the radix datapath emits results. It registers the datapath result alongside its addresses and tracks the frame's block-floating-point exponent, either latched or accumulated. It sits between the memory-read side and the memory-write side of a radix stage, replacing the fixed 5-lane, fixed-width address FIFO and exponent latch of the previous generation.

## Interface
- NLANE, 5, number of parallel lanes (butterfly points per beat)
- wIDX, 3, bank index width per lane
- wADDR, 8, bank address width per lane
- wD, 18, real/imag sample width per lane
- DEPTH, 32, sideband FIFO depth in entries (power of two, ≥ datapath latency + 2)
- wEXP, 4, exponent width
- EXP_ACC, 0, 0 = latch datapath exponent; 1 = saturating accumulate
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sop  in  1  frame start; clears exponent and sticky flags
- in_val  in  1  input beat valid (FIFO push)
- in_bank_index  in  NLANE*wIDX  lane k at [k*wIDX +: wIDX]
- in_bank_addr  in  NLANE*wADDR  lane k at [k*wADDR +: wADDR]
- dp_out_val  in  1  selected radix datapath output valid (FIFO pop)
- dp_real, dp_imag  in  NLANE*wD each  datapath results, lane-packed
- dp_exp  in  wEXP  exponent reported by selected datapath
- out_val  out  1  aligned output valid
- out_bank_index, out_bank_addr  out  NLANE*wIDX, NLANE*wADDR  replayed sideband
- out_real, out_imag  out  NLANE*wD each  registered datapath results
- exp_fb  out  wEXP  current frame exponent, fed back to datapaths
- exp_out  out  wEXP  exp_fb delayed one cycle, to write side
- fifo_level  out  $clog2(DEPTH+1)  occupied entries
- exp_sat  out  1  sticky: accumulation saturated
- err_overflow, err_underflow  out  1  sticky FIFO error flags

## Operation
- FIFO: circular buffer of DEPTH entries of {index,addr} for all lanes; write pointer, read pointer, level counter.
- Push on in_val when level < DEPTH, or when full with simultaneous pop. Push when full without pop: beat dropped, level unchanged, err_overflow set.
- Pop on dp_out_val. Pop when empty: out_val still asserted, out_bank_* = 0, err_underflow set, pointers and level unchanged.
- Push and pop in the same cycle with level in 1..DEPTH: level unchanged, both pointers advance. Push and pop with level 0: underflow (no write-through); push is stored, level becomes 1.
- Pointers wrap modulo DEPTH.
- Exponent register exp_fb: edge = dp_out_val & ~dp_out_val_d. EXP_ACC=0: on edge, exp_fb <= dp_exp. EXP_ACC=1: on edge, exp_fb <= min(exp_fb + dp_exp, 2^wEXP-1) using wEXP+1-bit sum; saturation sets exp_sat.
- sop has priority: same-cycle edge is ignored; exp_fb <= 0; exp_sat and error flags cleared. FIFO contents and pointers are not cleared by sop.

## Timing
- All outputs registered; reset value 0 for every output, FIFO empty, dp_out_val_d = 0.
- out_val, out_bank_*, out_real/out_imag: 1 cycle after dp_out_val/dp_* sampled.
- fifo_level reflects push/pop 1 cycle after the request cycle.
- exp_fb updates 1 cycle after the edge cycle; exp_out 1 cycle after exp_fb.
- Sticky flags assert 1 cycle after the offending cycle.
- Asynchronous reset mid-frame empties FIFO immediately; in-flight datapath results popping afterwards flag underflow.
- No backpressure: the upstream guarantees occupancy ≤ DEPTH in normal operation.

## Configuration
- MRD_SB_ERR_EN: defined → err_overflow/err_underflow implemented as above.
- Not defined → both ports tied to 0. Drop/underflow data behaviour is unchanged.
- exp_sat is always present.

## Test plan
- Push 10 beats with lane addr = beat number, pop 10 beats 25 cycles later → out_bank_addr lane 0 = 0..9 in order; fifo_level 10 → 0; no flags.
- Fill DEPTH=32, push one more with no pop → err_overflow=1, level stays 32. Then push+pop same cycle → level 32, no new error. sop → flag cleared.
- dp_out_val with level 0 → out_val=1, addresses 0, err_underflow=1. With MRD_SB_ERR_EN undefined → flag stays 0.
- EXP_ACC=0: dp_exp=3 on first valid of burst, then dp_exp=5 mid-burst → exp_fb=3 (mid-burst ignored). Next burst dp_exp=2 → exp_fb=2; exp_out follows one cycle later.
- EXP_ACC=1, wEXP=4: three bursts with dp_exp=6 → exp_fb 6, 12, 15; exp_sat=1.
- sop coincident with dp_out_val rising edge (dp_exp=7) → exp_fb=0. Assert rst_n low mid-burst → all outputs 0 asynchronously, level 0.
